// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded RAW hazard detection and a single-entry operand register toward execute.
// Define OPERAND_FETCH_BYPASS_EN to let a same-cycle writeback satisfy a pending source instead of stalling.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rf_a_ptr,
  output logic [4:0]      rf_b_ptr,
  input  logic [XLEN-1:0] rf_a,
  input  logic [XLEN-1:0] rf_b,
  input  logic            wb_en,
  input  logic [4:0]      wb_ptr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [31:0]     out_pc,
  input  logic            flush
);

  localparam int NREG = 32;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // x0 is hard-wired to zero; a bypassed source takes the writeback value.
  function automatic logic [XLEN-1:0] resolve_op(
    input logic [4:0]      rs,
    input logic            byp,
    input logic [XLEN-1:0] wbv,
    input logic [XLEN-1:0] rfv
  );
    logic [XLEN-1:0] v;
    v = rfv;
    if (rs == 5'd0) v = '0;
    else if (byp)   v = wbv;
    return v;
  endfunction

  // A source stalls if it is pending in the scoreboard (and not being written
  // back this cycle with bypass), or if the held output entry will write it.
  function automatic logic src_hazard(
    input logic [4:0]      rs,
    input logic            pend,
    input logic            byp,
    input logic            held_vld,
    input logic            held_we,
    input logic [4:0]      held_rd
  );
    logic h;
    h = 1'b0;
    if (rs != 5'd0) begin
      if (pend && !byp)                          h = 1'b1;
      if (held_vld && held_we && held_rd == rs)  h = 1'b1;
    end
    return h;
  endfunction

  logic            vld_p1;
  logic [XLEN-1:0] rs1_val_p1;
  logic [XLEN-1:0] rs2_val_p1;
  logic [4:0]      rd_p1;
  logic            rd_we_p1;
  logic [31:0]     pc_p1;
  logic [NREG-1:0] sb_q;

  logic            wb_live;
  logic            byp_a;
  logic            byp_b;
  logic            haz_a;
  logic            haz_b;
  logic            hazard;
  logic            accept;
  logic            out_fire;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] sb_clr;
  logic [NREG-1:0] sb_next;
  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;

  assign rf_a_ptr = in_rs1;
  assign rf_b_ptr = in_rs2;

  // Stage p0: hazard check and operand selection for the incoming instruction
  always_comb begin
    wb_live  = wb_en && (wb_ptr != 5'd0);
    byp_a    = BYPASS && wb_live && (wb_ptr == in_rs1);
    byp_b    = BYPASS && wb_live && (wb_ptr == in_rs2);
    haz_a    = src_hazard(in_rs1, sb_q[in_rs1], byp_a, vld_p1, rd_we_p1, rd_p1);
    haz_b    = src_hazard(in_rs2, sb_q[in_rs2], byp_b, vld_p1, rd_we_p1, rd_p1);
    hazard   = haz_a || haz_b;
    in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
    out_fire = vld_p1 && out_ready && !flush;

    rs1_val_p0 = resolve_op(in_rs1, byp_a, wb_data, rf_a);
    rs2_val_p0 = resolve_op(in_rs2, byp_b, wb_data, rf_b);

    sb_set = '0;
    sb_clr = '0;
    if (out_fire && rd_we_p1 && (rd_p1 != 5'd0)) sb_set[rd_p1]  = 1'b1;
    if (wb_live)                                 sb_clr[wb_ptr] = 1'b1;
    sb_next = (sb_q & ~sb_clr) | sb_set;
  end

  // Stage p1: held output entry and scoreboard state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      sb_q       <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      rd_p1      <= '0;
      rd_we_p1   <= 1'b0;
      pc_p1      <= '0;
    end else begin
      sb_q <= sb_next;
      if (flush)         vld_p1 <= 1'b0;
      else if (accept)   vld_p1 <= 1'b1;
      else if (out_fire) vld_p1 <= 1'b0;
      if (accept) begin
        rs1_val_p1 <= rs1_val_p0;
        rs2_val_p1 <= rs2_val_p0;
        rd_p1      <= in_rd;
        rd_we_p1   <= in_rd_we;
        pc_p1      <= in_pc;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_rs1_val = rs1_val_p1;
  assign out_rs2_val = rs2_val_p1;
  assign out_rd      = rd_p1;
  assign out_rd_we   = rd_we_p1;
  assign out_pc      = pc_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/bypass/flush/reset scenarios, then random traffic,
// all compared against a pending-register model with its own register file.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [31:0] in_pc;
  logic [4:0]  rf_a_ptr, rf_b_ptr;
  logic [31:0] rf_a, rf_b;
  logic        wb_en;
  logic [4:0]  wb_ptr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        flush;

  operand_fetch #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_pc(in_pc),
    .rf_a_ptr(rf_a_ptr), .rf_b_ptr(rf_b_ptr), .rf_a(rf_a), .rf_b(rf_b),
    .wb_en(wb_en), .wb_ptr(wb_ptr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file, written by the writeback port.
  logic [31:0] rf_mem [32];
  assign rf_a = (rf_a_ptr == 5'd0) ? 32'd0 : rf_mem[rf_a_ptr];
  assign rf_b = (rf_b_ptr == 5'd0) ? 32'd0 : rf_mem[rf_b_ptr];

  // Reference model: set of registers with an in-flight producer, plus one held entry.
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_v1, m_v2, m_pc;
  logic [4:0]  m_rd;
  bit          m_we;
  bit          last_acc;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_byp(input logic [4:0] rs);
`ifdef OPERAND_FETCH_BYPASS_EN
    return wb_en && (wb_ptr == rs) && (rs != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_stall_on(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_pend[rs] && !m_byp(rs)) return 1'b1;
    if (m_valid && m_we && m_rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (m_byp(rs))  return wb_data;
    return rf_mem[rs];
  endfunction

  // One clock: inputs are already driven; check combinational outputs mid-cycle,
  // advance model and register file at the edge, then check registered outputs.
  task automatic cycle();
    bit          exp_rdy, acc, fire;
    logic [31:0] v1, v2;
    #4;
    exp_rdy = (!m_valid || out_ready) && !m_stall_on(in_rs1) && !m_stall_on(in_rs2) && !flush;
    if (rst_n) chk("in_ready", in_ready, exp_rdy);
    chk("rf_a_ptr", rf_a_ptr, in_rs1);
    chk("rf_b_ptr", rf_b_ptr, in_rs2);
    acc  = in_valid && exp_rdy;
    fire = m_valid && out_ready && !flush;
    v1   = m_val(in_rs1);
    v2   = m_val(in_rs2);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_v1 = '0; m_v2 = '0; m_pc = '0; m_rd = '0; m_we = 1'b0;
      acc = 1'b0;
    end else begin
      if (wb_en && wb_ptr != 5'd0) m_pend[wb_ptr] = 1'b0;
      if (fire && m_we && m_rd != 5'd0) m_pend[m_rd] = 1'b1;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1; m_v1 = v1; m_v2 = v2; m_pc = in_pc; m_rd = in_rd; m_we = in_rd_we;
      end else if (fire) m_valid = 1'b0;
    end
    if (wb_en && wb_ptr != 5'd0) rf_mem[wb_ptr] = wb_data;
    last_acc = acc;
    chk("out_valid", out_valid, m_valid);
    if (m_valid || !rst_n) begin
      chk("out_rs1_val", out_rs1_val, m_v1);
      chk("out_rs2_val", out_rs2_val, m_v2);
      chk("out_rd", out_rd, m_rd);
      chk("out_rd_we", out_rd_we, m_we);
      chk("out_pc", out_pc, m_pc);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    in_pc = $urandom; wb_en = 1'b0; wb_ptr = '0; wb_data = '0; out_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_pc = $urandom;
  endtask

  task automatic drain();
    idle();
    cycle();
    cycle();
    for (int r = 1; r < 32; r++) begin
      if (m_pend[r]) begin
        wb_en = 1'b1; wb_ptr = 5'(r); wb_data = $urandom;
        cycle();
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_valid = 1'b0; m_v1 = '0; m_v2 = '0; m_pc = '0; m_rd = '0; m_we = 1'b0; last_acc = 1'b0;

    // Reset, then in_ready in the first cycle after release
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'd0);
    idle();
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    cycle();
    chk("post_rst_accept", last_acc, 1'b1);

    // Independent stream: back-to-back with no stall
    drain();
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    cycle();
    chk("indep_acc0", last_acc, 1'b1);
    issue(5'd1, 5'd2, 5'd4, 1'b1);
    cycle();
    chk("indep_acc1", last_acc, 1'b1);
    chk("indep_valid", out_valid, 1'b1);
    chk("indep_rd", out_rd, 5'd4);

    // RAW on x5 resolved by a writeback two cycles after the producer issues
    drain();
    issue(5'd1, 5'd2, 5'd5, 1'b1);
    cycle();
    issue(5'd5, 5'd0, 5'd6, 1'b1);
    cycle();
    chk("raw_stall_held", last_acc, 1'b0);
    wb_en = 1'b1; wb_ptr = 5'd5; wb_data = 32'hDEADBEEF;
    cycle();
`ifdef OPERAND_FETCH_BYPASS_EN
    chk("raw_byp_acc", last_acc, 1'b1);
`else
    chk("raw_wb_cycle_stall", last_acc, 1'b0);
    wb_en = 1'b0;
    cycle();
    chk("raw_late_acc", last_acc, 1'b1);
`endif
    chk("raw_val", out_rs1_val, 32'hDEADBEEF);

    // Held entry writing x7 blocks a reader of x7 until it leaves and x7 is written back
    drain();
    issue(5'd1, 5'd2, 5'd7, 1'b1);
    cycle();
    out_ready = 1'b0;
    issue(5'd0, 5'd7, 5'd8, 1'b1);
    cycle();
    chk("held_stall0", last_acc, 1'b0);
    cycle();
    chk("held_stall1", last_acc, 1'b0);
    chk("held_rd", out_rd, 5'd7);
    out_ready = 1'b1;
    cycle();
    chk("held_left_stall", last_acc, 1'b0);
    wb_en = 1'b1; wb_ptr = 5'd7; wb_data = 32'h0000_0077;
    cycle();
`ifdef OPERAND_FETCH_BYPASS_EN
    chk("held_byp_acc", last_acc, 1'b1);
`else
    chk("held_wb_stall", last_acc, 1'b0);
    wb_en = 1'b0;
    cycle();
    chk("held_late_acc", last_acc, 1'b1);
`endif
    chk("held_rs2_val", out_rs2_val, 32'h0000_0077);

    // x0: never a hazard, always zero, wb to x0 ignored
    drain();
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb_en = 1'b1; wb_ptr = 5'd0; wb_data = 32'h0000_1234;
    cycle();
    chk("x0_acc", last_acc, 1'b1);
    chk("x0_val", out_rs1_val, 32'd0);
    wb_en = 1'b0;
    issue(5'd0, 5'd0, 5'd1, 1'b0);
    cycle();
    chk("x0_no_stall", last_acc, 1'b1);

    // Flush drops the held x9 entry without marking x9 pending
    drain();
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    cycle();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0;
    issue(5'd9, 5'd0, 5'd0, 1'b0);
    cycle();
    chk("flush_no_sb", last_acc, 1'b1);

    // Reset in the middle of a stall clears pending state
    drain();
    issue(5'd0, 5'd0, 5'd10, 1'b1);
    cycle();
    issue(5'd10, 5'd0, 5'd11, 1'b1);
    cycle();
    cycle();
    chk("stall_before_rst", last_acc, 1'b0);
    rst_n = 1'b0;
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rs1", out_rs1_val, 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("rst_release_acc", last_acc, 1'b1);

    // Random traffic
    drain();
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_rd_we  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_ptr    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32, register data width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 in_valid, in_ready  in/out  1,1  decoded-instruction handshake.
REQ-005 in_rs1, in_rs2, in_rd  in  5 each  source and destination register indices.
REQ-006 in_rd_we  in  1  instruction writes in_rd.
REQ-007 in_pc  in  32  instruction address, passed through.
REQ-008 rf_a_ptr, rf_b_ptr  out  5 each  register-file read pointers.
REQ-009 rf_a, rf_b  in  32 each  combinational register-file read data; index 0 reads zero.
REQ-010 wb_en, wb_ptr, wb_data  in  1,5,32  writeback port, mirrored from the register-file write port.
REQ-011 out_valid, out_ready  out/in  1,1  operand handshake toward execute.
REQ-012 out_rs1_val, out_rs2_val  out  32 each  resolved operands.
REQ-013 out_rd, out_rd_we, out_pc  out  5,1,32  passed-through fields.
REQ-014 flush  in  1  discard the held output entry.

Function
REQ-015 rf_a_ptr SHALL equal in_rs1 and rf_b_ptr SHALL equal in_rs2 combinationally at all times.
REQ-016 The block SHALL hold a single output entry; accept = in_valid && in_ready; out_valid SHALL rise on the clock edge after accept (1-cycle latency).
REQ-017 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-018 A 32-bit scoreboard SHALL set bit rd on the edge where out_valid && out_ready && out_rd_we && out_rd != 0.
REQ-019 The scoreboard SHALL clear bit wb_ptr on the edge where wb_en is high; on a simultaneous set and clear of the same bit, set wins.
REQ-020 hazard SHALL be high when either nonzero source index (rs1 or rs2) has its scoreboard bit set and is not bypassable, or when out_valid && out_rd_we && out_rd equals that source.
REQ-021 Index 0 SHALL never cause a hazard and SHALL always resolve to value 0.
REQ-022 An operand SHALL be bypassable when wb_en && wb_ptr == rs && rs != 0; the operand captured is then wb_data, else rf_a/rf_b.
REQ-023 The output entry SHALL stay stable while out_valid && !out_ready.
REQ-024 A simultaneous out handshake and accept SHALL replace the entry with no bubble.
REQ-025 flush SHALL clear out_valid on the next edge without setting any scoreboard bit, even when out_ready is high.
REQ-026 flush SHALL block accept in the same cycle.
REQ-027 A wb_en with wb_ptr 0 SHALL be ignored.

Reset
REQ-028 While rst_n is low at a clock edge, out_valid, the scoreboard, out_rs1_val, out_rs2_val, out_rd, out_rd_we and out_pc SHALL become 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset SHALL take priority over flush, accept and writeback on the same edge.

Configuration
REQ-031 With macro OPERAND_FETCH_BYPASS_EN defined, REQ-022 bypass SHALL be implemented.
REQ-032 Without OPERAND_FETCH_BYPASS_EN, no operand is bypassable:
- a source whose scoreboard bit is set SHALL stall, including in the writeback cycle;
- the operand SHALL be read from rf_a/rf_b on a later cycle, after the bit clears.

Verification
REQ-033 Independent stream: add x3,x1,x2 then add x4,x1,x2 with out_ready=1 -> back-to-back out_valid, no stall.
REQ-034 RAW: issue x5=..., then an instruction with rs1=5; wb x5=0xDEADBEEF two cycles later.
- With bypass: accepted in the wb cycle with out_rs1_val=0xDEADBEEF.
- Without bypass: accepted one cycle later.
REQ-035 Held-entry hazard: out_rd=7 held with out_ready=0, next instruction rs2=7 -> in_ready=0 until the entry leaves and the wb for x7 arrives.
REQ-036 x0: rs1=0, rd=0, wb_en with wb_ptr=0, wb_data=0x1234 -> out_rs1_val=0, no scoreboard bit set, no stall.
REQ-037 flush with out_valid=1, out_rd=9, out_ready=1 -> out_valid=0 next cycle, scoreboard bit 9 stays 0.
REQ-038 rst_n low mid-stall with scoreboard bits set -> all outputs 0, scoreboard 0, in_ready=1 the cycle after release.
